hex_rate_counter: RTL and testbench
===================================

# hex_rate_counter

Timed 4-bit digit source that sits directly upstream of the board's hex-to-7-segment decoder. It divides the board clock into a selectable step rate and steps a 4-bit value 0x0–0xF up or down, wrapping at the ends. The value can be frozen or parallel-loaded from switches. `Count` drives the decoder's four data inputs; `Tick` and `Wrap` are status pulses for LEDs or a cascaded next digit.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per second (simulation uses 4).
- `DIV_W`, default 28: divider width; must hold 4*TICKS_PER_SEC-1.
- `Clock`  in  1  board clock (CLOCK_50); all logic is on its rising edge.
- `Resetn`  in  1  reset. One clock; reset is synchronous and active-low.
- `Enable`  in  1  run; low freezes both the divider and the counter.
- `Rate`  in  2  step rate: 00 = every clock, 01 = 1 Hz, 10 = 0.5 Hz, 11 = 0.25 Hz.
- `Up`  in  1  direction: 1 = increment, 0 = decrement.
- `Load`  in  1  synchronous parallel load.
- `LoadVal`  in  4  value for load (SW[3:0]).
- `Count`  out  4  current digit, to the decoder.
- `Tick`  out  1  one-cycle pulse, high while a freshly stepped or loaded `Count` is first visible.
- `Wrap`  out  1  one-cycle pulse, coincident with `Tick`, when a step crossed F→0 (up) or 0→F (down).

## Operation
- Reload value R(Rate): 00→0, 01→TICKS_PER_SEC-1, 10→2*TICKS_PER_SEC-1, 11→4*TICKS_PER_SEC-1.
- Divider `D` (DIV_W bits) counts down. The registered copy of `Rate` is `RateQ`.
- Per-edge priority, highest first:
  1. `Resetn`=0: `Count`←0, `D`←R(Rate), `RateQ`←Rate, `Tick`←0, `Wrap`←0.
  2. `Load`=1: `Count`←LoadVal, `D`←R(Rate), `Tick`←1, `Wrap`←0. Load acts regardless of `Enable`.
  3. `Rate`≠`RateQ`: `RateQ`←Rate, `D`←R(Rate), no step, `Tick`←0.
  4. `Enable`=0: hold everything; `Tick`←0, `Wrap`←0.
  5. `D`==0 (step): `Count`←Count±1 mod 16, `D`←R(RateQ), `Tick`←1, `Wrap`←(wrap crossed).
  6. Otherwise: `D`←D-1, `Tick`←0, `Wrap`←0.
- Count arithmetic is 4-bit modulo with no saturation. The divider never underflows, because the reload happens at 0.
- Direction change takes effect on the next step only; it never resets `D`.
- Reset mid-count discards the divider phase. The first step after reset is a full period later.

## Timing
- All outputs are registered. Reset values: `Count`=0, `Tick`=0, `Wrap`=0.
- Step period for Rate r = R(r)+1 enabled cycles. Rate 00 steps on every enabled clock.
- Latency of the first step: after `Resetn` rises with `Enable`=1, the first step is visible R(Rate)+1 edges later (rate 01: TICKS_PER_SEC edges).
- Load latency: one edge. `Count`=LoadVal and `Tick`=1 in the cycle after the edge that sampled `Load`=1. The next step follows R+1 enabled cycles later.
- Load and step in the same cycle: load wins, and that step is lost.
- `Enable` low for N cycles stretches the current period by exactly N cycles; the phase is preserved.
- A rate change costs one cycle (the reload). The new period then runs in full.

## Structure
- Package `hex_counter_pkg` holds:
  - rate encoding constants `RATE_FAST`, `RATE_1HZ`, `RATE_HALF`, `RATE_QTR`;
  - function `rate_reload(rate, ticks)` returning the DIV_W-bit R.
- Sub-module `rate_divider` contains `D`, `RateQ`, the reload logic and the step-pulse output.
- The top level holds the count/load/Tick/Wrap register logic. The top level of the board instantiates this block and feeds `Count` to the existing decoder.

## Test plan
All scenarios use TICKS_PER_SEC=4.
1. Reset with Rate=01, Up=1, Enable=1, then release → `Count` reads 0,0,0,0,1 on edges 0–4, `Tick` is high only in the cycle `Count`=1, and the period is 4 cycles thereafter.
2. Rate=00, Up=1, starting from 0xE → `Count`=F, 0, 1 on consecutive cycles, `Wrap`=1 only with 0. With Up=0 from 0x1 → 0, F, with `Wrap`=1 at F.
3. Load=1 with LoadVal=0x9 in the same cycle a step is due → `Count`=9 (not an incremented value), `Tick`=1, `Wrap`=0, next step to 0xA 4 cycles later.
4. Rate=01, `Enable` dropped for 3 cycles mid-period → the step is delayed by exactly 3 cycles and `Count` is held throughout.
5. Rate switched 01→11 mid-period → one reload cycle with no step, then the next step 16 cycles later.
6. `Resetn` low for one cycle with `Count`=7 mid-period → `Count`=0 next cycle, and a full 4-cycle period elapses before `Count`=1.

Source files
------------

// File: rtl/hex_counter_pkg.sv
// Shared rate encoding and divider reload calculation for the hex rate counter.
package hex_counter_pkg;

    localparam logic [1:0] RATE_FAST = 2'b00;  // step on every enabled clock
    localparam logic [1:0] RATE_1HZ  = 2'b01;
    localparam logic [1:0] RATE_HALF = 2'b10;
    localparam logic [1:0] RATE_QTR  = 2'b11;

    // Wide enough for any sensible DIV_W; callers truncate to their own width.
    localparam int RELOAD_W = 32;

    // Divider reload value: one less than the number of cycles per step.
    function automatic logic [RELOAD_W-1:0] rate_reload(input logic [1:0]  rate,
                                                        input int unsigned ticks);
        logic [RELOAD_W-1:0] r;
        r = '0;
        case (rate)
            RATE_1HZ:  r = RELOAD_W'(ticks - 1);
            RATE_HALF: r = RELOAD_W'(2 * ticks - 1);
            RATE_QTR:  r = RELOAD_W'(4 * ticks - 1);
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hex_rate_counter_divider.sv
// Down-counting clock divider that produces a one-cycle step request at the
// selected rate. Tracks the registered rate so a rate change costs one reload.
module rate_divider
    import hex_counter_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int          DIV_W         = 28
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Enable,
    input  logic       Load,
    input  logic [1:0] Rate,
    output logic       step
);

    logic [DIV_W-1:0] d;
    logic [1:0]       rate_q;
    logic [DIV_W-1:0] reload_new;
    logic [DIV_W-1:0] reload_cur;

    assign reload_new = DIV_W'(rate_reload(Rate, TICKS_PER_SEC));
    assign reload_cur = DIV_W'(rate_reload(rate_q, TICKS_PER_SEC));

    // A step is due only when nothing of higher priority claims this edge.
    assign step = !Load && (Rate == rate_q) && Enable && (d == '0);

    // Divider and registered rate, with load/rate-change reloads taking priority.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!Resetn) begin
            d      <= reload_new;
            rate_q <= Rate;
        end else if (Load) begin
            d <= reload_new;
        end else if (Rate != rate_q) begin
            rate_q <= Rate;
            d      <= reload_new;
        end else if (!Enable) begin
            d <= d;
        end else if (d == '0) begin
            d <= reload_cur;
        end else begin
            d <= d - DIV_W'(1);
        end
    end

endmodule

// File: rtl/hex_rate_counter.sv
// Timed 4-bit up/down digit source feeding a hex-to-7-segment decoder.
// Holds the digit, load path and the Tick/Wrap status pulses.
module hex_rate_counter
    import hex_counter_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int          DIV_W         = 28
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Enable,
    input  logic [1:0] Rate,
    input  logic       Up,
    input  logic       Load,
    input  logic [3:0] LoadVal,
    output logic [3:0] Count,
    output logic       Tick,
    output logic       Wrap
);

    logic       step;
    logic [3:0] count_next;
    logic       crossed;

    rate_divider #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .DIV_W         (DIV_W)
    ) u_div (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Enable (Enable),
        .Load   (Load),
        .Rate   (Rate),
        .step   (step)
    );

    // 4-bit modulo arithmetic wraps naturally; flag the F->0 / 0->F crossing.
    assign count_next = Up ? Count + 4'd1 : Count - 4'd1;
    assign crossed    = Up ? (Count == 4'hF) : (Count == 4'h0);

    // Digit register and status pulses; load beats a coincident step.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            Count <= 4'h0;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
        end else if (Load) begin
            Count <= LoadVal;
            Tick  <= 1'b1;
            Wrap  <= 1'b0;
        end else if (step) begin
            Count <= count_next;
            Tick  <= 1'b1;
            Wrap  <= crossed;
        end else begin
            Tick <= 1'b0;
            Wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed self-checking bench for hex_rate_counter with TICKS_PER_SEC=4.
module tb_hex_rate_counter;

    localparam int unsigned TPS = 4;

    logic       Clock;
    logic       Resetn;
    logic       Enable;
    logic [1:0] Rate;
    logic       Up;
    logic       Load;
    logic [3:0] LoadVal;
    logic [3:0] Count;
    logic       Tick;
    logic       Wrap;

    int n_tests = 0;
    int n_fail  = 0;

    hex_rate_counter #(
        .TICKS_PER_SEC (TPS),
        .DIV_W         (28)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Enable  (Enable),
        .Rate    (Rate),
        .Up      (Up),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Count   (Count),
        .Tick    (Tick),
        .Wrap    (Wrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Apply a one-cycle reset at the given rate and release it.
    task automatic do_reset(input logic [1:0] r);
        Resetn = 1'b0; Rate = r; Load = 1'b0; Enable = 1'b1; Up = 1'b1; LoadVal = 4'h0;
        cyc();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b1; Enable = 1'b1; Rate = 2'b01; Up = 1'b1;
        Load = 1'b1; LoadVal = 4'h5;
        cyc();
        Load = 1'b0;
        Resetn = 1'b0;
        cyc();
        Resetn = 1'b1;
        n_tests++;
        if (Count !== 4'h0 || Tick !== 1'b0 || Wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: Count=%h Tick=%b Wrap=%b, required 0 0 0", Count, Tick, Wrap);
        end
    endtask

    // Rate 01: Count 0,0,0,1 on edges 1..4, then period of 4.
    task automatic test_first_step();
        logic [3:0] exp_c;
        logic       exp_t;
        do_reset(2'b01);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            exp_c = 4'(i / 4);
            exp_t = (i % 4 == 0);
            n_tests++;
            if (Count !== exp_c || Tick !== exp_t || Wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL first_step edge %0d: Count=%h Tick=%b Wrap=%b, required %h %b 0",
                         i, Count, Tick, Wrap, exp_c, exp_t);
            end
        end
    endtask

    // First step after reset lands R+1 edges later for each slow rate.
    task automatic test_rate_periods();
        int r_cyc;
        for (int r = 1; r <= 3; r++) begin
            r_cyc = (r == 1) ? 4 : (r == 2) ? 8 : 16;
            do_reset(2'(r));
            for (int i = 1; i < r_cyc; i++) cyc();
            n_tests++;
            if (Count !== 4'h0 || Tick !== 1'b0) begin
                n_fail++;
                $display("FAIL rate%0d_early: Count=%h Tick=%b, required 0 0", r, Count, Tick);
            end
            cyc();
            n_tests++;
            if (Count !== 4'h1 || Tick !== 1'b1) begin
                n_fail++;
                $display("FAIL rate%0d_step: Count=%h Tick=%b, required 1 1", r, Count, Tick);
            end
        end
    endtask

    // Rate 00 wrap in both directions.
    task automatic test_wrap();
        logic [3:0] exp_up [3] = '{4'hF, 4'h0, 4'h1};
        logic       wrp_up [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] exp_dn [3] = '{4'h0, 4'hF, 4'hE};
        logic       wrp_dn [3] = '{1'b0, 1'b1, 1'b0};
        do_reset(2'b00);
        Load = 1'b1; LoadVal = 4'hE;
        cyc();
        Load = 1'b0;
        n_tests++;
        if (Count !== 4'hE || Tick !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_load_e: Count=%h Tick=%b, required e 1", Count, Tick);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (Count !== exp_up[i] || Tick !== 1'b1 || Wrap !== wrp_up[i]) begin
                n_fail++;
                $display("FAIL wrap_up step %0d: Count=%h Tick=%b Wrap=%b, required %h 1 %b",
                         i, Count, Tick, Wrap, exp_up[i], wrp_up[i]);
            end
        end
        Up = 1'b0; Load = 1'b1; LoadVal = 4'h1;
        cyc();
        Load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (Count !== exp_dn[i] || Tick !== 1'b1 || Wrap !== wrp_dn[i]) begin
                n_fail++;
                $display("FAIL wrap_down step %0d: Count=%h Tick=%b Wrap=%b, required %h 1 %b",
                         i, Count, Tick, Wrap, exp_dn[i], wrp_dn[i]);
            end
        end
    endtask

    // Load coincident with a due step: load wins, next step 4 cycles later.
    task automatic test_load_vs_step();
        do_reset(2'b01);
        cyc(); cyc(); cyc();
        Load = 1'b1; LoadVal = 4'h9;
        cyc();
        Load = 1'b0;
        n_tests++;
        if (Count !== 4'h9 || Tick !== 1'b1 || Wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL load_vs_step: Count=%h Tick=%b Wrap=%b, required 9 1 0", Count, Tick, Wrap);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_tests++;
            if (Count !== ((i == 4) ? 4'hA : 4'h9) || Tick !== (i == 4)) begin
                n_fail++;
                $display("FAIL load_next_step edge %0d: Count=%h Tick=%b, required %h %b",
                         i, Count, Tick, (i == 4) ? 4'hA : 4'h9, (i == 4));
            end
        end
    endtask

    // Enable low for 3 cycles mid-period delays the step by exactly 3.
    task automatic test_enable_hold();
        do_reset(2'b01);
        cyc(); cyc();
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (Count !== 4'h0 || Tick !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_hold %0d: Count=%h Tick=%b, required 0 0", i, Count, Tick);
            end
        end
        Enable = 1'b1;
        cyc();
        n_tests++;
        if (Count !== 4'h0 || Tick !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_resume: Count=%h Tick=%b, required 0 0", Count, Tick);
        end
        cyc();
        n_tests++;
        if (Count !== 4'h1 || Tick !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_step: Count=%h Tick=%b, required 1 1", Count, Tick);
        end
    endtask

    // Rate 01 -> 11 mid-period: one reload edge, then 16 cycles to the step.
    task automatic test_rate_change();
        do_reset(2'b01);
        cyc();
        Rate = 2'b11;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            n_tests++;
            if (Count !== 4'h0 || Tick !== 1'b0) begin
                n_fail++;
                $display("FAIL rate_change wait %0d: Count=%h Tick=%b, required 0 0", i, Count, Tick);
            end
        end
        cyc();
        n_tests++;
        if (Count !== 4'h1 || Tick !== 1'b1) begin
            n_fail++;
            $display("FAIL rate_change step: Count=%h Tick=%b, required 1 1", Count, Tick);
        end
    endtask

    // Reset mid-period with Count=7 discards phase; full period to Count=1.
    task automatic test_reset_mid();
        do_reset(2'b01);
        Load = 1'b1; LoadVal = 4'h7;
        cyc();
        Load = 1'b0;
        cyc();
        Resetn = 1'b0;
        cyc();
        Resetn = 1'b1;
        n_tests++;
        if (Count !== 4'h0 || Tick !== 1'b0 || Wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: Count=%h Tick=%b Wrap=%b, required 0 0 0", Count, Tick, Wrap);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_tests++;
            if (Count !== ((i == 4) ? 4'h1 : 4'h0) || Tick !== (i == 4)) begin
                n_fail++;
                $display("FAIL reset_mid period edge %0d: Count=%h Tick=%b, required %h %b",
                         i, Count, Tick, (i == 4) ? 4'h1 : 4'h0, (i == 4));
            end
        end
    endtask

    initial begin
        Resetn = 1'b1; Enable = 1'b1; Rate = 2'b01; Up = 1'b1; Load = 1'b0; LoadVal = 4'h0;
        #2;
        test_reset();
        test_first_step();
        test_rate_periods();
        test_wrap();
        test_load_vs_step();
        test_enable_hold();
        test_rate_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
